// File: rtl/train_ctrl_pkg.sv
// Shared constants and types for the train controller phase timer.
// Holds the default widths, the prescaler divide and the timer FSM encoding.
package train_ctrl_pkg;

    localparam int TIME_W       = 19;
    localparam int STATE_W      = 4;
    localparam int PRESCALE_DIV = 50000;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        RUN,
        EXPIRED
    } timer_state_t;

endpackage

// File: rtl/tick_prescaler.sv
// Free-running divider that makes a one-clk tick every DIV cycles.
// Ports: clk, rst_n (async low), clr (restart phase), tick_out (strobe).
module tick_prescaler #(
    parameter int DIV = 50000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    output logic tick_out
);

    localparam int CW = (DIV > 2) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt;
    logic          wrap;

    assign wrap     = (cnt == CW'(DIV - 1));
    // Suppressed during clr so a restart never inherits a stale tick.
    assign tick_out = wrap && !clr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr || wrap) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/train_phase_timer.sv
// Phase down-counter: reloads on every controller state change, counts the
// selected duration down on ticks and pulses done for one cycle on expiry.
// Ports: clk, rst_n (async low), tin (duration, 0 = untimed), present_state,
// tick (count enable), count (remaining), busy (timed phase running),
// done (expiry pulse). Option macro: TIMER_PRESCALE_EN replaces the tick
// port with an internal PRESCALE_DIV divider restarted on every load.
module train_phase_timer #(
    parameter int TIME_W       = train_ctrl_pkg::TIME_W,
    parameter int STATE_W      = train_ctrl_pkg::STATE_W,
    parameter int PRESCALE_DIV = train_ctrl_pkg::PRESCALE_DIV
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [TIME_W-1:0]  tin,
    input  logic [STATE_W-1:0] present_state,
    input  logic               tick,
    output logic [TIME_W-1:0]  count,
    output logic               busy,
    output logic               done
);

    import train_ctrl_pkg::*;

    timer_state_t       state;
    logic [STATE_W-1:0] prev_state;
    logic               chg;
    logic               tick_en;

    assign chg = (present_state != prev_state);

`ifdef TIMER_PRESCALE_EN
    logic unused_tick;
    assign unused_tick = tick;

    tick_prescaler #(
        .DIV(PRESCALE_DIV)
    ) u_prescaler (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (state == LOAD),
        .tick_out(tick_en)
    );
`else
    localparam int unused_div = PRESCALE_DIV;
    assign tick_en = tick;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            prev_state <= '0;
            count      <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            prev_state <= present_state;
            done       <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (chg) state <= LOAD;
                end
                // The selector output is valid one cycle after the change,
                // so tin is sampled here rather than in IDLE.
                LOAD: begin
                    if (chg) begin
                        busy  <= 1'b0;
                        state <= LOAD;
                    end else if (tin == '0) begin
                        count <= '0;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        count <= tin;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                // A state change beats a coincident final tick.
                RUN: begin
                    if (chg) begin
                        busy  <= 1'b0;
                        state <= LOAD;
                    end else if (tick_en && count != '0) begin
                        if (count == TIME_W'(1)) begin
                            count <= '0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= EXPIRED;
                        end else begin
                            count <= count - TIME_W'(1);
                        end
                    end
                end
                EXPIRED: begin
                    state <= chg ? LOAD : IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_train_phase_timer.sv
// Self-checking bench for train_phase_timer: vector table with a queue of
// expected outputs, plus hand sequences for untimed, sparse tick and reset.
module tb_train_phase_timer;

    localparam int TW = 19;
    localparam int SW = 4;
`ifdef TIMER_PRESCALE_EN
    localparam int DIV = 4;
`else
    localparam int DIV = 50000;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [TW-1:0] tin = '0;
    logic [SW-1:0] present_state = '0;
    logic          tick = 1'b0;
    logic [TW-1:0] count;
    logic          busy;
    logic          done;

    train_phase_timer #(
        .TIME_W      (TW),
        .STATE_W     (SW),
        .PRESCALE_DIV(DIV)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .tin          (tin),
        .present_state(present_state),
        .tick         (tick),
        .count        (count),
        .busy         (busy),
        .done         (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        string         nm;
        logic [SW-1:0] ps;
        logic [TW-1:0] tin;
        logic          tick;
        logic          cc;
        logic [TW-1:0] cnt;
        logic          busy;
        logic          done;
    } vec_t;

    typedef struct {
        string         nm;
        logic          cc;
        logic [TW-1:0] cnt;
        logic          busy;
        logic          done;
    } exp_t;

    vec_t tbl[$];
    exp_t sb[$];
    int   applied = 0;
    int   errs = 0;

    function automatic vec_t mk(string nm, int ps, int t, bit tk,
                                bit cc, int c, bit b, bit d);
        vec_t v;
        v.nm = nm;
        v.ps = SW'(ps);
        v.tin = TW'(t);
        v.tick = tk;
        v.cc = cc;
        v.cnt = TW'(c);
        v.busy = b;
        v.done = d;
        return v;
    endfunction

    task automatic chk(string nm, int act, int req);
        applied++;
        if (act !== req) begin
            errs++;
            $display("FAIL %s: got %0d, required %0d", nm, act, req);
        end
    endtask

    task automatic step(vec_t v);
        exp_t e;
        present_state = v.ps;
        tin = v.tin;
        tick = v.tick;
        e.nm = v.nm;
        e.cc = v.cc;
        e.cnt = v.cnt;
        e.busy = v.busy;
        e.done = v.done;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        applied++;
        if ((e.cc && count !== e.cnt) || busy !== e.busy ||
            done !== e.done) begin
            errs++;
            $display("FAIL %s: count=%0d busy=%0b done=%0b, required count=%0d busy=%0b done=%0b",
                     e.nm, count, busy, done, e.cnt, e.busy, e.done);
        end
    endtask

    initial begin
        int at;
        bit ok;
        #23;
        chk("reset_count", int'(count), 0);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

`ifdef TIMER_PRESCALE_EN
        present_state = 4'd3;
        tin = 19'd2;
        tick = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("pre_load_count", int'(count), 2);
        at = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                at = n;
                break;
            end
        end
        chk("pre_done_at", at, 8);
`else
        // Basic expiry, tin change during RUN must be ignored
        tbl.push_back(mk("basic_e0", 3, 5, 1, 1, 0, 0, 0));
        tbl.push_back(mk("basic_e1", 3, 5, 1, 1, 5, 1, 0));
        tbl.push_back(mk("basic_c4", 3, 9, 1, 1, 4, 1, 0));
        tbl.push_back(mk("basic_c3", 3, 9, 1, 1, 3, 1, 0));
        tbl.push_back(mk("basic_c2", 3, 5, 1, 1, 2, 1, 0));
        tbl.push_back(mk("basic_c1", 3, 5, 1, 1, 1, 1, 0));
        tbl.push_back(mk("basic_done", 3, 5, 1, 1, 0, 0, 1));
        tbl.push_back(mk("basic_post", 3, 5, 1, 1, 0, 0, 0));
        tbl.push_back(mk("basic_post2", 3, 5, 1, 1, 0, 0, 0));
        // Untimed phase
        tbl.push_back(mk("untimed_e0", 6, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk("untimed_e1", 6, 0, 1, 1, 0, 0, 0));
        tbl.push_back(mk("untimed_idle", 6, 0, 1, 1, 0, 0, 0));
        // Abort and reload
        tbl.push_back(mk("abort_e0", 3, 10, 1, 1, 0, 0, 0));
        tbl.push_back(mk("abort_e1", 3, 10, 1, 1, 10, 1, 0));
        for (int c = 9; c >= 4; c--)
            tbl.push_back(mk("abort_run", 3, 10, 1, 1, c, 1, 0));
        tbl.push_back(mk("abort_chg", 4, 3, 1, 0, 0, 0, 0));
        tbl.push_back(mk("abort_load", 4, 3, 1, 1, 3, 1, 0));
        tbl.push_back(mk("abort_c2", 4, 3, 1, 1, 2, 1, 0));
        tbl.push_back(mk("abort_c1", 4, 3, 1, 1, 1, 1, 0));
        tbl.push_back(mk("abort_done", 4, 3, 1, 1, 0, 0, 1));
        tbl.push_back(mk("abort_post", 4, 3, 1, 1, 0, 0, 0));
        // Final tick coincides with a state change
        tbl.push_back(mk("simul_e0", 5, 2, 1, 1, 0, 0, 0));
        tbl.push_back(mk("simul_e1", 5, 2, 1, 1, 2, 1, 0));
        tbl.push_back(mk("simul_c1", 5, 2, 1, 1, 1, 1, 0));
        tbl.push_back(mk("simul_chg", 7, 2, 1, 0, 0, 0, 0));
        tbl.push_back(mk("simul_load", 7, 2, 1, 1, 2, 1, 0));
        tbl.push_back(mk("simul_c1b", 7, 2, 1, 1, 1, 1, 0));
        tbl.push_back(mk("simul_done", 7, 2, 1, 1, 0, 0, 1));
        tbl.push_back(mk("simul_post", 7, 2, 1, 1, 0, 0, 0));

        foreach (tbl[i]) step(tbl[i]);

        // Untimed phase held for 100 cycles
        present_state = 4'd6;
        tin = '0;
        tick = 1'b1;
        ok = 1'b1;
        for (int n = 0; n < 100; n++) begin
            @(posedge clk);
            #1;
            if (busy || done) ok = 1'b0;
        end
        chk("untimed_quiet", int'(ok), 1);

        // Sparse ticks: every 4th cycle after the load edge
        present_state = 4'd8;
        tin = 19'd2;
        tick = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        chk("sparse_load", int'(count), 2);
        at = -1;
        for (int n = 1; n <= 20; n++) begin
            tick = (n % 4 == 0);
            @(posedge clk);
            #1;
            if (done) begin
                at = n;
                break;
            end
        end
        tick = 1'b0;
        chk("sparse_done_win", int'(at >= 7 && at <= 9), 1);

        // Asynchronous reset mid-count
        present_state = 4'd9;
        tin = 19'd20;
        tick = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        chk("rst_pre_busy", int'(busy), 1);
        chk("rst_pre_count", int'(count), 17);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_async_count", int'(count), 0);
        chk("rst_async_busy", int'(busy), 0);
        chk("rst_async_done", int'(done), 0);
        @(negedge clk);
        rst_n = 1'b1;
        tick = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_after_done", int'(done), 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", applied, errs);
        $finish;
    end

endmodule
